// File: rtl/dm_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the DM.
// The slave modport is the arbiter's view; master is the environment's view.
interface dm_arbiter_if #(
   parameter int WORD_WIDTH = 32
);
   // requester 0 (CPU MEM stage)
   logic                  req0;
   logic                  we0;
   logic [WORD_WIDTH-1:0] addr0;
   logic [WORD_WIDTH-1:0] wdata0;
   logic                  ack0;
   // requester 1 (debug / program loader)
   logic                  req1;
   logic                  we1;
   logic [WORD_WIDTH-1:0] addr1;
   logic [WORD_WIDTH-1:0] wdata1;
   logic                  ack1;
   // shared read return
   logic [WORD_WIDTH-1:0] rdata;
   // data memory port
   logic [WORD_WIDTH-1:0] memAddr;
   logic [WORD_WIDTH-1:0] memWData;
   logic                  memWrite;
   logic                  memRead;
   logic [WORD_WIDTH-1:0] memRData;
   // status
   logic                  busy;
   logic                  grantId;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  memRData,
      output ack0, ack1, rdata,
      output memAddr, memWData, memWrite, memRead,
      output busy, grantId
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output memRData,
      input  ack0, ack1, rdata,
      input  memAddr, memWData, memWrite, memRead,
      input  busy, grantId
   );
endinterface

// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the single-ported data
// memory. Each accepted request runs IDLE -> BUSY -> ACK: one DM access cycle,
// then a one-cycle ack to the winner with read data registered.
module dm_arbiter #(
   parameter int WORD_WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   dm_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;

   logic                  lat_we;
   logic [WORD_WIDTH-1:0] lat_addr;
   logic [WORD_WIDTH-1:0] lat_wdata;
   logic                  grant_id;
   logic                  last_grant;
   logic [WORD_WIDTH-1:0] rdata_q;
   logic                  ack0_q;
   logic                  ack1_q;

   logic                  any_req;
   logic                  sel_id;

   // Pick the winner among active requests; on a tie the one not served last.
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      any_req = bus.req0 | bus.req1;
      sel_id  = 1'b0;
      if (bus.req0 && bus.req1) begin
         sel_id = ~last_grant;
      end else if (bus.req1) begin
         sel_id = 1'b1;
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: state elements use non-blocking assignments so all flops update together at the edge.
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: accept in IDLE, then exactly one BUSY and one ACK cycle.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (any_req) state_nxt = BUSY;
         BUSY:    state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: DM strobes only in BUSY; the write strobe is gated by
   // rst_n so a reset edge landing in BUSY never commits the write.
   always_comb begin
      bus.memWrite = 1'b0;
      bus.memRead  = 1'b0;
      bus.busy     = 1'b0;
      unique case (state)
         BUSY: begin
            bus.memWrite = lat_we & rst_n;
            bus.memRead  = ~lat_we;
            bus.busy     = 1'b1;
         end
         ACK: begin
            bus.busy     = 1'b1;
         end
         default: begin
            bus.busy     = 1'b0;
         end
      endcase
   end

   // Transaction latch, read-data capture, ack pulse and round-robin history.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         grant_id   <= 1'b0;
         last_grant <= 1'b1;
         rdata_q    <= '0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  grant_id  <= sel_id;
                  lat_we    <= sel_id ? bus.we1    : bus.we0;
                  lat_addr  <= sel_id ? bus.addr1  : bus.addr0;
                  lat_wdata <= sel_id ? bus.wdata1 : bus.wdata0;
               end
            end
            BUSY: begin
               if (!lat_we) begin
                  rdata_q <= bus.memRData;
               end
               ack0_q     <= ~grant_id;
               ack1_q     <= grant_id;
               last_grant <= grant_id;
            end
            ACK: begin
               ack0_q <= 1'b0;
               ack1_q <= 1'b0;
            end
            default: begin
               ack0_q <= 1'b0;
               ack1_q <= 1'b0;
            end
         endcase
      end
   end

   // Latched payload is always visible on the DM port; strobes qualify it.
   assign bus.memAddr  = lat_addr;
   assign bus.memWData = lat_wdata;
   assign bus.rdata    = rdata_q;
   assign bus.ack0     = ack0_q;
   assign bus.ack1     = ack1_q;
   assign bus.grantId  = grant_id;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural data memory, a reference
// memory model and an in-order scoreboard of expected acks.
module tb_dm_arbiter;

   localparam int W = 32;

   typedef struct {
      logic         id;
      logic [W-1:0] rdata;
   } exp_t;

   logic clk;
   logic rst_n;

   dm_arbiter_if #(.WORD_WIDTH(W)) bus ();

   dm_arbiter #(.WORD_WIDTH(W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // behavioural DM: combinational read, write on rising edge
   logic [W-1:0] dm_mem [16];
   assign bus.memRData = dm_mem[bus.memAddr[3:0]];
   always @(posedge clk) begin
      if (bus.memWrite) dm_mem[bus.memAddr[3:0]] <= bus.memWData;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int           n_vec = 0;
   int           n_err = 0;
   exp_t         sb_q[$];
   logic [W-1:0] ref_mem [16];
   logic [W-1:0] model_rdata;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // record the expected ack for a transaction in grant order
   task automatic expect_txn(input logic id, input logic we, input logic [W-1:0] addr,
                             input logic [W-1:0] wdata);
      exp_t e;
      e.id = id;
      if (we) begin
         ref_mem[addr[3:0]] = wdata;
      end else begin
         model_rdata = ref_mem[addr[3:0]];
      end
      e.rdata = model_rdata;
      sb_q.push_back(e);
   endtask

   task automatic drive_req(input logic id, input logic we, input logic [W-1:0] addr,
                            input logic [W-1:0] wdata);
      if (id) begin
         bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
      end else begin
         bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
      end
   endtask

   // one complete solo transaction with per-cycle checks
   task automatic run_txn(input logic id, input logic we, input logic [W-1:0] addr,
                          input logic [W-1:0] wdata);
      drive_req(id, we, addr, wdata);
      expect_txn(id, we, addr, wdata);
      @(negedge clk);
      check("busy_in_busy", bus.busy, 1);
      check("memWrite_in_busy", bus.memWrite, we);
      check("memRead_in_busy", bus.memRead, !we);
      check("memAddr_in_busy", bus.memAddr, addr);
      if (we) check("memWData_in_busy", bus.memWData, wdata);
      @(negedge clk);
      check("ack0_in_ack", bus.ack0, !id);
      check("ack1_in_ack", bus.ack1, id);
      check("grantId_in_ack", bus.grantId, id);
      check("strobes_in_ack", {bus.memWrite, bus.memRead}, 0);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(negedge clk);
      check("busy_after_txn", bus.busy, 0);
      check("ack_cleared", bus.ack0 | bus.ack1, 0);
   endtask

   // scoreboard: every ack must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (bus.ack0 || bus.ack1) begin
         n_vec++;
         assert (sb_q.size() != 0) else begin
            n_err++;
            $error("FAIL sb_unexpected_ack: observed ack0=%b ack1=%b expected no ack", bus.ack0, bus.ack1);
         end
         if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_ack_onehot", bus.ack0 & bus.ack1, 0);
            check("sb_ack_id", bus.ack1, e.id);
            check("sb_rdata", bus.rdata, e.rdata);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
      model_rdata = '0;

      // reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_ack0", bus.ack0, 0);
      check("rst_ack1", bus.ack1, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_rdata", bus.rdata, 0);
      check("rst_grantId", bus.grantId, 0);
      check("rst_memWrite", bus.memWrite, 0);
      check("rst_memRead", bus.memRead, 0);
      check("rst_memAddr", bus.memAddr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // solo write by requester 0, then read back by requester 1
      run_txn(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
      run_txn(1'b1, 1'b0, 32'd5, 32'h0);

      // both requesting continuously from reset: strict alternation 0,1,0,1
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_rdata = '0;
      drive_req(1'b0, 1'b1, 32'd1, 32'hAAAA_0001);
      drive_req(1'b1, 1'b1, 32'd2, 32'hBBBB_0002);
      for (int k = 0; k < 4; k++) begin
         logic win;
         win = k[0];
         if (win) expect_txn(1'b1, 1'b1, 32'd2, 32'hBBBB_0002);
         else     expect_txn(1'b0, 1'b1, 32'd1, 32'hAAAA_0001);
         @(negedge clk);
         check("rr_busy", bus.busy, 1);
         check("rr_memAddr", bus.memAddr, win ? 32'd2 : 32'd1);
         check("rr_memWrite", bus.memWrite, 1);
         @(negedge clk);
         check("rr_ack0", bus.ack0, !win);
         check("rr_ack1", bus.ack1, win);
         if (k == 3) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
         end
         @(negedge clk);
         check("rr_idle_gap", bus.busy, 0);
      end
      run_txn(1'b1, 1'b0, 32'd1, 32'h0);
      run_txn(1'b0, 1'b0, 32'd2, 32'h0);

      // reset during BUSY of a write: no commit, no ack
      run_txn(1'b0, 1'b1, 32'd7, 32'h1234_5678);
      drive_req(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFF);
      @(negedge clk);
      check("abort_memWrite_before_rst", bus.memWrite, 1);
      rst_n = 1'b0;
      bus.req0 = 1'b0;
      #1;
      check("abort_memWrite_gated", bus.memWrite, 0);
      model_rdata = '0;
      @(negedge clk);
      check("abort_busy", bus.busy, 0);
      check("abort_ack0", bus.ack0, 0);
      check("abort_rdata", bus.rdata, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_no_late_ack", bus.ack0 | bus.ack1, 0);
      run_txn(1'b1, 1'b0, 32'd7, 32'h0);

      // payload change during BUSY does not affect the latched read
      run_txn(1'b1, 1'b1, 32'd3, 32'hA5A5_0003);
      run_txn(1'b1, 1'b1, 32'd9, 32'h0909_0909);
      drive_req(1'b0, 1'b0, 32'd3, 32'h0);
      expect_txn(1'b0, 1'b0, 32'd3, 32'h0);
      @(negedge clk);
      check("hold_memAddr_busy", bus.memAddr, 3);
      bus.addr0 = 32'd9;
      #1;
      check("hold_memAddr_after_change", bus.memAddr, 3);
      check("hold_memRData", bus.memRData, 32'hA5A5_0003);
      @(negedge clk);
      check("hold_ack0", bus.ack0, 1);
      check("hold_rdata", bus.rdata, 32'hA5A5_0003);
      bus.req0 = 1'b0;
      @(negedge clk);
      check("hold_idle", bus.busy, 0);

      // quiet period
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("quiet_memWrite", bus.memWrite, 0);
         check("quiet_memRead", bus.memRead, 0);
         check("quiet_ack0", bus.ack0, 0);
         check("quiet_ack1", bus.ack1, 0);
         check("quiet_busy", bus.busy, 0);
      end

      check("sb_drained", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
